oam_dma_controller: RTL
=======================

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named clk_ph1 and rst.
REQ-002 clk_ph1  in  1  system clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 cpu_addr  in  16  CPU address bus.
REQ-005 cpu_data_out  in  8  CPU write data.
REQ-006 cpu_R_nW  in  1  CPU read/not-write.
REQ-007 Data_bus_in  in  8  memory read data, returned to the CPU unchanged.
REQ-008 Addr_bus  out  16  arbitrated address to memory.
REQ-009 Data_bus_out  out  8  arbitrated write data to memory.
REQ-010 R_nW  out  1  arbitrated read/not-write to memory.
REQ-011 cpu_rdy  out  1  1 = CPU may advance; 0 = CPU stalled.
REQ-012 dma_active  out  1  1 while the DMA owns the bus.

Function
REQ-013 States SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-014 A parity bit SHALL toggle every clock from reset (0 = get cycle, 1 = put cycle).
REQ-015 IDLE: Addr_bus/Data_bus_out/R_nW SHALL pass cpu_addr/cpu_data_out/cpu_R_nW combinationally; cpu_rdy=1, dma_active=0.
REQ-016 IDLE with cpu_R_nW=0 and cpu_addr=16'h4014 SHALL latch page=cpu_data_out, clear idx to 0, and enter HALT next cycle.
REQ-017 cpu_rdy SHALL equal 1 only in IDLE; dma_active SHALL equal 1 in every other state.
REQ-018 HALT: dummy cycle with the bus driven as READ of {page,idx}; next state ALIGN if parity=1, else READ.
REQ-019 ALIGN: dummy read of {page,idx}; next state READ, taken once only.
REQ-020 READ: Addr_bus={page,idx}, R_nW=1; Data_bus_in latched into the byte register at end of cycle; next state WRITE.
REQ-021 WRITE: Addr_bus=16'h2004, Data_bus_out=byte register, R_nW=0; idx increments mod 256.
REQ-022 WRITE with idx=8'hFF SHALL go to IDLE; otherwise WRITE SHALL go to READ.
REQ-023 Stall length from the $4014 write: 513 cycles if HALT falls on parity 0, 514 if on parity 1.
REQ-024 Page 8'hFF SHALL read FF00..FFFF with no carry into the high byte.
REQ-025 Writes to $4014 while not in IDLE SHALL be ignored, with page unchanged.
REQ-026 A $4014 read SHALL NOT trigger DMA.
REQ-027 The first IDLE cycle after WRITE SHALL again pass the CPU through and accept a new $4014 write.

Reset
REQ-028 While rst=0: state=IDLE, parity=0, page=0, idx=0, byte register=0, cpu_rdy=1, dma_active=0, bus in pass-through.
REQ-029 Reset asserted mid-transfer SHALL abort immediately, with no further write to $2004 after release.

Structure
REQ-030 A shared package SHALL hold OAM_DMA_ADDR=16'h4014, OAMDATA_ADDR=16'h2004, and the state enumeration.
REQ-031 The block SHALL be a single module with no sub-modules; bus outputs are combinational from state, and all other state is registered.

Verification
REQ-032 Write 8'h02 to $4014 at parity 0 -> cpu_rdy low exactly 513 cycles; 256 reads 0200..02FF each followed by a $2004 write of the read byte.
REQ-033 Same write landing at parity 1 -> 514-cycle stall, with exactly one ALIGN cycle.
REQ-034 Page 8'hFF, memory byte = low address -> last WRITE data 8'hFF, last read address FFFF, then IDLE.
REQ-035 Write $4014=8'h05 during an active page-02 DMA -> all reads remain 02xx; page unchanged.
REQ-036 rst low at idx=8'h80 -> next cycle cpu_rdy=1, pass-through; no $2004 write after release.
REQ-037 CPU read of $4014 and CPU write to $4015 -> no stall; outputs mirror the CPU bus.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// OAM DMA shared constants.
// Register addresses and FSM state encodings.
package oam_dma_pkg;

    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA controller: stalls the CPU and copies a
// 256-byte page to $2004 as read/write pairs.
module oam_dma_controller
    import oam_dma_pkg::*;
(
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_R_nW,
    input  logic [7:0]  Data_bus_in,
    output logic [15:0] Addr_bus,
    output logic [7:0]  Data_bus_out,
    output logic        R_nW,
    output logic        cpu_rdy,
    output logic        dma_active
);

    logic [2:0] state;
    logic       parity;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] byte_reg;
    logic       trig;

    assign trig = !cpu_R_nW && (cpu_addr == OAM_DMA_ADDR);

    // Get/put parity, free-running from reset.
    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) parity <= 1'b0;
        else      parity <= ~parity;
    end

    // Transfer sequencing, page/index and data latch.
    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            byte_reg <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        page  <= cpu_data_out;
                        idx   <= 8'h00;
                        state <= ST_HALT;
                    end
                end
                ST_HALT:  state <= parity ? ST_ALIGN : ST_READ;
                ST_ALIGN: state <= ST_READ;
                ST_READ: begin
                    byte_reg <= Data_bus_in;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    idx   <= idx + 8'd1;
                    state <= (idx == 8'hFF) ? ST_IDLE : ST_READ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus arbitration: CPU passes through only when idle.
    always_comb begin
        Addr_bus     = cpu_addr;
        Data_bus_out = cpu_data_out;
        R_nW         = cpu_R_nW;
        case (state)
            ST_HALT, ST_ALIGN, ST_READ: begin
                Addr_bus     = {page, idx};
                Data_bus_out = byte_reg;
                R_nW         = 1'b1;
            end
            ST_WRITE: begin
                Addr_bus     = OAMDATA_ADDR;
                Data_bus_out = byte_reg;
                R_nW         = 1'b0;
            end
            default: ;
        endcase
    end

    assign cpu_rdy    = (state == ST_IDLE);
    assign dma_active = !cpu_rdy;

endmodule
